// File: rtl/blk_b4987e.sv
// Avalon-ST timing adapter: upstream source with ready latency L feeding a ready-latency-0 sink.
// A show-ahead FIFO holds beats already granted by in_ready so a downstream stall never loses one.
module blk_b4987e #(
    parameter int DATA_WIDTH       = 72,
    parameter int IN_READY_LATENCY = 1,
    parameter int DEPTH            = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  in_ready,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  overflow
);

    localparam int L     = IN_READY_LATENCY;
    localparam int PTR_W = $clog2(DEPTH);
    // Wide enough to hold count + pending (at most DEPTH + L < 2*DEPTH).
    localparam int CNT_W = PTR_W + 2;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      pending;
    logic [L-1:0]          hist;
    logic                  init_done;
    logic                  push;
    logic                  pop;
    logic                  violation;

    always_comb begin
        // NOTE: the accumulator gets a default before the loop, so no latch is inferred.
        pending = '0;
        for (int i = 0; i < L; i++) begin
            pending = pending + CNT_W'(hist[i]);
        end
    end

    // Grants still in flight are reserved; a pop this cycle is deliberately not credited.
    assign in_ready  = init_done && ((count + pending) <= CNT_W'(DEPTH - 1));

    assign push      = in_valid &  hist[L-1];
    assign violation = in_valid & ~hist[L-1];
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign out_data  = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            init_done <= 1'b0;
            hist      <= '0;
            overflow  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples pre-edge values.
            init_done <= 1'b1;
            hist      <= L'({hist, in_ready});
            if (violation) begin
                overflow <= 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is reset so out_data reads zero after any reset, including mid-stream.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_blk_b4987e.sv
// Directed bench for blk_b4987e: one instance at L=1/DEPTH=4, one at L=3/DEPTH=8,
// with an upstream driver honouring the ready latency and a FIFO scoreboard.
module tb_blk_b4987e;

    localparam int DW = 72;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          rdy_a, vld_a, ordy_a, ov_a, ovf_a;
    logic [DW-1:0] id_a, od_a;
    logic          rdy_b, vld_b, ordy_b, ov_b, ovf_b;
    logic [DW-1:0] id_b, od_b;

    blk_b4987e #(.DATA_WIDTH(DW), .IN_READY_LATENCY(1), .DEPTH(4)) dut_a (
        .clk(clk), .reset_n(reset_n), .in_ready(rdy_a), .in_valid(vld_a), .in_data(id_a),
        .out_ready(ordy_a), .out_valid(ov_a), .out_data(od_a), .overflow(ovf_a)
    );

    blk_b4987e #(.DATA_WIDTH(DW), .IN_READY_LATENCY(3), .DEPTH(8)) dut_b (
        .clk(clk), .reset_n(reset_n), .in_ready(rdy_b), .in_valid(vld_b), .in_data(id_b),
        .out_ready(ordy_b), .out_valid(ov_b), .out_data(od_b), .overflow(ovf_b)
    );

    int            n_cmp = 0;
    int            n_bad = 0;
    int            cur, lat, dep;
    logic [3:0]    hist_tb;
    bit            init_m, exp_ovf;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] base;
    int            seq, popped;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] want);
        n_cmp++;
        if (obs !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, want, $time);
        end
    endtask

    task automatic sel(input int c);
        cur = c;
        lat = (c != 0) ? 3 : 1;
        dep = (c != 0) ? 8 : 4;
    endtask

    task automatic drive(input bit v, input logic [DW-1:0] d, input bit ordy);
        vld_a = 1'b0; id_a = '0; ordy_a = 1'b0;
        vld_b = 1'b0; id_b = '0; ordy_b = 1'b0;
        if (cur == 0) begin
            vld_a = v; id_a = d; ordy_a = ordy;
        end else begin
            vld_b = v; id_b = d; ordy_b = ordy;
        end
    endtask

    task automatic observe(output logic r, output logic v, output logic [DW-1:0] d, output logic f);
        if (cur == 0) begin
            r = rdy_a; v = ov_a; d = od_a; f = ovf_a;
        end else begin
            r = rdy_b; v = ov_b; d = od_b; f = ovf_b;
        end
    endtask

    // Asserts reset wherever the caller is, checks outputs drop at once, releases on a falling edge.
    task automatic do_reset();
        logic r, v, f;
        logic [DW-1:0] d;
        reset_n = 1'b0;
        #1;
        observe(r, v, d, f);
        check("rst_in_ready", r, 0);
        check("rst_out_valid", v, 0);
        check("rst_out_data", d, 0);
        check("rst_overflow", f, 0);
        drive(0, '0, 0);
        exp_q.delete();
        hist_tb = '0;
        init_m  = 1'b0;
        exp_ovf = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // One clock cycle, entered and left on a falling edge.
    task automatic step(input bit ordy, input bit send, input bit bad);
        logic r, v, f;
        logic [DW-1:0] d;
        int  pend;
        bit  grant;
        bit  did_bad;
        observe(r, v, d, f);
        pend = 0;
        for (int i = 0; i < lat; i++) pend += int'(hist_tb[i]);
        check("in_ready", r, init_m && (exp_q.size() + pend <= dep - 1));
        check("out_valid", v, exp_q.size() != 0);
        check("overflow", f, exp_ovf);
        if (v && ordy && exp_q.size() != 0) begin
            check("out_data", d, exp_q.pop_front());
            popped++;
        end
        grant   = hist_tb[lat-1];
        did_bad = 1'b0;
        if (grant && send) begin
            check("push_room", exp_q.size() < dep, 1);
            exp_q.push_back(base + DW'(seq));
            drive(1, base + DW'(seq), ordy);
            seq++;
        end else if (bad && !grant) begin
            drive(1, 72'hFF_DEADBEEF_DEADBEEF, ordy);
            did_bad = 1'b1;
        end else begin
            drive(0, '0, ordy);
        end
        hist_tb = {hist_tb[2:0], r};
        @(negedge clk);
        init_m = 1'b1;
        if (did_bad) exp_ovf = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b1;
        sel(0);
        drive(0, '0, 0);
        #2;

        // Reset release: in_ready 0 on the first edge, 1 after it.
        do_reset();
        step(1, 0, 0);
        step(1, 0, 0);
        check("rel_in_ready_up", rdy_a, 1);

        // Streaming 16 beats with out_ready held high.
        base = '0; seq = 0; popped = 0;
        for (int i = 0; i < 100 && seq < 16; i++) step(1, 1, 0);
        repeat (3) step(1, 0, 0);
        check("stream_beats", popped, 16);

        // Backpressure: fill to DEPTH, then drain back-to-back.
        base = 72'h5A_0000_0000_0000_0000; seq = 0; popped = 0;
        repeat (8) step(0, 1, 0);
        check("bp_count", exp_q.size(), 4);
        check("bp_in_ready_low", rdy_a, 0);
        check("bp_out_valid", ov_a, 1);
        repeat (4) step(1, 0, 0);
        check("bp_drained", popped, 4);
        step(1, 0, 0);

        // Protocol violation right after reset: beat dropped, overflow sticky.
        do_reset();
        step(1, 0, 1);
        check("viol_flag", ovf_a, 1);
        base = 72'h11_0000_0000_0000_1000; seq = 0; popped = 0;
        for (int i = 0; i < 100 && seq < 6; i++) step(1, 1, 0);
        repeat (3) step(1, 0, 0);
        check("viol_beats", popped, 6);
        check("viol_sticky", ovf_a, 1);

        // Mid-operation reset with three beats buffered.
        base = 72'h22_0000_0000_0000_2000; seq = 0;
        for (int i = 0; i < 20 && exp_q.size() < 3; i++) step(0, 1, 0);
        check("mid_buffered", exp_q.size(), 3);
        #2;
        do_reset();
        repeat (4) step(1, 0, 0);
        base = 72'h33_0000_0000_0000_3000; seq = 0; popped = 0;
        for (int i = 0; i < 100 && seq < 3; i++) step(1, 1, 0);
        repeat (3) step(1, 0, 0);
        check("mid_new_beats", popped, 3);

        // L=3, DEPTH=8: 64 beats, out_ready toggling, some grants left unused.
        sel(1);
        do_reset();
        base = 72'hC3_0000_0000_0000_4000; seq = 0; popped = 0;
        for (int i = 0; i < 600 && popped < 64; i++) begin
            step(i % 2 == 0, seq < 64 && (i % 7 != 3), 0);
        end
        check("l3_beats", popped, 64);
        check("l3_overflow", ovf_b, 0);
        check("l3_empty", ov_b, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
